// File: rtl/fp_float2int_pkg.sv
`default_nettype none
// ==== fp_float2int_pkg: shared DLFloat16/int32 constants and types | Rev 1.0 ====
package fp_float2int_pkg;

  localparam int DL_EXP_W = 6;
  localparam int DL_MAN_W = 9;
  localparam int DL_BIAS  = 31;
  localparam int DL_SIG_W = DL_MAN_W + 1;

  localparam logic [14:0] DL_NAN_MAG = 15'h7FFF;

  localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT32_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_SIGN  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    K_NORM  = 3'd0,
    K_ZERO  = 3'd1,
    K_NAN   = 3'd2,
    K_UNDER = 3'd3,
    K_MIN   = 3'd4,
    K_SAT   = 3'd5
  } kind_t;

endpackage
`default_nettype wire

// File: rtl/fp_dl16_classify.sv
`default_nettype none
// ==== fp_dl16_classify: DLFloat16 field split, class and alignment shift | Rev 1.0 ====
module fp_dl16_classify
  import fp_float2int_pkg::*;
#(
  parameter int EXP_W = DL_EXP_W,
  parameter int MAN_W = DL_MAN_W,
  parameter int BIAS  = DL_BIAS,
  parameter int INT_W = 32
) (
  input  logic [EXP_W+MAN_W:0] float_in,
  output kind_t                kind,
  output logic                 sign,
  output logic                 shift_left,
  output logic [4:0]           count,
  output logic [MAN_W:0]       sig
);

  localparam logic [EXP_W-1:0] BIAS_E = EXP_W'(BIAS);
  localparam logic [EXP_W-1:0] SAT_E  = EXP_W'(BIAS + INT_W - 1);
  localparam logic [EXP_W-1:0] LEFT_E = EXP_W'(BIAS + MAN_W);

  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man_f;

  assign sign  = float_in[EXP_W+MAN_W];
  assign exp_f = float_in[MAN_W +: EXP_W];
  assign man_f = float_in[MAN_W-1:0];
  assign sig   = {1'b1, man_f};

  // Priority order matters: zero and NaN encodings would otherwise fall into
  // the underflow and saturate ranges.
  always_comb begin
    kind       = K_NORM;
    shift_left = 1'b1;
    count      = 5'd0;
    if (float_in[EXP_W+MAN_W-1:0] == '0) begin
      kind = K_ZERO;
    end else if (float_in[EXP_W+MAN_W-1:0] == DL_NAN_MAG) begin
      kind = K_NAN;
    end else if (exp_f < BIAS_E) begin
      kind = K_UNDER;
    end else if (exp_f >= SAT_E) begin
      kind = (sign && man_f == '0 && exp_f == SAT_E) ? K_MIN : K_SAT;
    end else if (exp_f >= LEFT_E) begin
      count = 5'(exp_f - LEFT_E);
    end else begin
      shift_left = 1'b0;
      count      = 5'(LEFT_E - exp_f);
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp_float2int.sv
`default_nettype none
// ==== fp_float2int: DLFloat16 -> int32 (truncating), 1-bit/cycle aligner | Rev 1.0 ====
module fp_float2int
  import fp_float2int_pkg::*;
#(
  parameter int EXP_W = DL_EXP_W,
  parameter int MAN_W = DL_MAN_W,
  parameter int BIAS  = DL_BIAS,
  parameter int INT_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] float_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INT_W-1:0]     int_out,
  output logic                 out_overflow,
  output logic                 out_invalid,
  output logic                 out_inexact
);

  kind_t            cls_kind;
  logic             cls_sign;
  logic             cls_left;
  logic [4:0]       cls_count;
  logic [MAN_W:0]   cls_sig;

  state_t           state;
  kind_t            kind_q;
  logic             sign_q;
  logic             left_q;
  logic [4:0]       cnt;
  logic [INT_W-1:0] mag;
  logic             sticky;

  fp_dl16_classify #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W),
    .BIAS  (BIAS),
    .INT_W (INT_W)
  ) u_classify (
    .float_in   (float_in),
    .kind       (cls_kind),
    .sign       (cls_sign),
    .shift_left (cls_left),
    .count      (cls_count),
    .sig        (cls_sig)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
      int_out      <= '0;
      out_overflow <= 1'b0;
      out_invalid  <= 1'b0;
      out_inexact  <= 1'b0;
      kind_q       <= K_ZERO;
      sign_q       <= 1'b0;
      left_q       <= 1'b1;
      cnt          <= 5'd0;
      mag          <= '0;
      sticky       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            kind_q   <= cls_kind;
            sign_q   <= cls_sign;
            left_q   <= cls_left;
            cnt      <= cls_count;
            mag      <= INT_W'(cls_sig);
            sticky   <= 1'b0;
            in_ready <= 1'b0;
            state    <= (cls_count != 5'd0) ? ST_SHIFT : ST_SIGN;
          end
        end
        ST_SHIFT: begin
          if (left_q) begin
            mag <= mag << 1;
          end else begin
            mag    <= mag >> 1;
            sticky <= sticky | mag[0];
          end
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) state <= ST_SIGN;
        end
        ST_SIGN: begin
          out_overflow <= 1'b0;
          out_invalid  <= 1'b0;
          out_inexact  <= 1'b0;
          case (kind_q)
            K_ZERO:  int_out <= '0;
            K_NAN: begin
              int_out     <= INT_W'(INT32_MIN);
              out_invalid <= 1'b1;
            end
            K_UNDER: begin
              int_out     <= '0;
              out_inexact <= 1'b1;
            end
            K_MIN:   int_out <= INT_W'(INT32_MIN);
            K_SAT: begin
              int_out      <= sign_q ? INT_W'(INT32_MIN) : INT_W'(INT32_MAX);
              out_overflow <= 1'b1;
            end
            default: begin
              // Aligned magnitude is below 2^31, so negation never wraps.
              int_out     <= sign_q ? -mag : mag;
              out_inexact <= sticky;
            end
          endcase
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fp_float2int.sv
`default_nettype none
// ==== tb_fp_float2int: directed vector bench for fp_float2int | Rev 1.0 ====
module tb_fp_float2int;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] float_in = 16'h0000;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] int_out;
  logic        out_overflow;
  logic        out_invalid;
  logic        out_inexact;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [15:0] f;
    logic [31:0] r;
    logic [2:0]  fl;   // {overflow, invalid, inexact}
    int          lat;
  } vec_t;

  vec_t vecs[18];

  fp_float2int dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .float_in     (float_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .int_out      (int_out),
    .out_overflow (out_overflow),
    .out_invalid  (out_invalid),
    .out_inexact  (out_inexact)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Handshakes one operand, returns the cycle index at which out_valid rose
  // (accept cycle = 0); leaves the result pending in DONE.
  task automatic start_op(input logic [15:0] f, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    in_valid = 1'b1;
    float_in = f;
    @(posedge clk); #1;
    in_valid = 1'b0;
    float_in = 16'h5555;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    vecs[0]  = '{16'h0000, 32'h0000_0000, 3'b000, 2};
    vecs[1]  = '{16'h8000, 32'h0000_0000, 3'b000, 2};
    vecs[2]  = '{16'h3E00, 32'h0000_0001, 3'b000, 11};
    vecs[3]  = '{16'hD1E8, 32'hFFFF_FC18, 3'b000, 2};
    vecs[4]  = '{16'h4080, 32'h0000_0002, 3'b001, 10};
    vecs[5]  = '{16'h2000, 32'h0000_0000, 3'b001, 2};
    vecs[6]  = '{16'hFC00, 32'h8000_0000, 3'b000, 2};
    vecs[7]  = '{16'h7C00, 32'h7FFF_FFFF, 3'b100, 2};
    vecs[8]  = '{16'h7FFF, 32'h8000_0000, 3'b010, 2};
    vecs[9]  = '{16'hBE00, 32'hFFFF_FFFF, 3'b000, 11};
    vecs[10] = '{16'h7BFF, 32'h7FE0_0000, 3'b000, 23};
    vecs[11] = '{16'hFBFF, 32'h8020_0000, 3'b000, 23};
    vecs[12] = '{16'h7E00, 32'h7FFF_FFFF, 3'b100, 2};
    vecs[13] = '{16'hFC01, 32'h8000_0000, 3'b100, 2};
    vecs[14] = '{16'h3C00, 32'h0000_0000, 3'b001, 2};
    vecs[15] = '{16'h3FFF, 32'h0000_0001, 3'b001, 11};
    vecs[16] = '{16'h41FF, 32'h0000_0003, 3'b001, 10};
    vecs[17] = '{16'h4100, 32'h0000_0003, 3'b000, 10};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_int_out", int_out, 32'd0);
    chk("reset_flags", 32'({out_overflow, out_invalid, out_inexact}), 32'd0);

    for (int i = 0; i < 18; i++) begin
      start_op(vecs[i].f, lat);
      chk($sformatf("int_%h", vecs[i].f), int_out, vecs[i].r);
      chk($sformatf("flags_%h", vecs[i].f),
          32'({out_overflow, out_invalid, out_inexact}), 32'(vecs[i].fl));
      chk($sformatf("latency_%h", vecs[i].f), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("busy_%h", vecs[i].f), 32'(in_ready), 32'd0);
      release_op();
      chk($sformatf("idle_%h", vecs[i].f), 32'({out_valid, in_ready}), 32'b01);
    end

    // Backpressure: result held stable, new operands ignored.
    start_op(16'hD1E8, lat);
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      float_in = 16'h3E00;
      @(posedge clk); #1;
      chk("bp_int_out", int_out, 32'hFFFF_FC18);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    release_op();
    repeat (4) @(posedge clk);
    #1 chk("bp_no_ghost", 32'({out_valid, in_ready}), 32'b01);

    // Reset mid-SHIFT discards the operation.
    in_valid = 1'b1;
    float_in = 16'h4C00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1 chk("rst_discarded", 32'(out_valid), 32'd0);
    start_op(16'h3E00, lat);
    chk("post_rst_int", int_out, 32'd1);
    chk("post_rst_latency", 32'(lat), 32'd11);
    release_op();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
